line_memory: RTL
================

LINE_MEMORY -- requirements
Module: line_memory

Interface
REQ-001 SHALL provide parameter LINE_BYTES, default 16, meaning bytes transferred per request (power of two, 1..64).
REQ-002 SHALL provide parameter ADDR_W, default 20, meaning byte-address width; storage depth is 2^ADDR_W bytes.
REQ-003 SHALL provide parameter READ_LAT, default 2, meaning cycles from read accept to response (1..15).
REQ-004 SHALL provide parameter WRITE_LAT, default 1, meaning cycles from write accept to write acknowledge (1..15).
REQ-005 mclk  input  1  memory clock; all state changes on rising edge.
REQ-006 rst  input  1  reset; asynchronous assert, active-low.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  block can accept a request this cycle.
REQ-009 req_we  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  ADDR_W  byte address of first byte; any alignment.
REQ-011 req_wdata  input  8*LINE_BYTES  write data; byte n goes to address req_addr+n.
REQ-012 req_wmask  input  LINE_BYTES  per-byte write enable; bit n gates byte n.
REQ-013 rsp_valid  output  1  response (read data or write ack) present.
REQ-014 rsp_ready  input  1  consumer accepts response.
REQ-015 rsp_rdata  output  8*LINE_BYTES  read data, byte n = mem[req_addr+n]; zero for write acks.
REQ-016 rsp_we  output  1  echoes req_we of the request being answered.

Function
REQ-017 SHALL accept a request on a rising edge where req_valid and req_ready are both 1; other cycles leave state unchanged.
REQ-018 SHALL hold at most one outstanding request; FSM states IDLE, WAIT, RESP.
REQ-019 IDLE: req_ready=1, rsp_valid=0; on accept -> WAIT, latency counter loaded with (READ_LAT or WRITE_LAT) - 1, request fields captured.
REQ-020 WAIT: req_ready=0; counter decrements each cycle; at counter 0 -> RESP next edge, so rsp_valid rises exactly LAT cycles after the accept edge.
REQ-021 RESP: rsp_valid=1 with rsp_rdata/rsp_we stable until the edge where rsp_ready=1; then -> IDLE.
REQ-022 Back-to-back: req_ready SHALL be 0 in the RESP cycle; a new request is accepted no earlier than the cycle after the response handshake.
REQ-023 Reads SHALL snapshot memory on the accept edge; the snapshot is returned regardless of later activity.
REQ-024 Writes SHALL update only masked bytes, committed on the accept edge; a read accepted afterwards SHALL return the new bytes.
REQ-025 Address arithmetic SHALL wrap modulo 2^ADDR_W: byte n uses (req_addr+n) mod 2^ADDR_W.
REQ-026 req_wmask all-zero SHALL leave memory unchanged but still produce a write ack after WRITE_LAT.
REQ-027 Inputs other than rsp_ready SHALL be ignored while not in IDLE.
REQ-028 Memory contents SHALL be unaffected by reset and power up undefined; the bench preloads by hierarchical access.

Reset
REQ-029 While rst=0: state IDLE, req_ready=0, rsp_valid=0, rsp_we=0, rsp_rdata=0, counter=0.
REQ-030 req_ready SHALL rise on the first rising edge after rst deasserts.
REQ-031 Reset asserted in WAIT or RESP SHALL abort the pending response; a write already accepted remains committed.

Verification
REQ-032 Preload mem[0x00000..0x0000F]=0x00..0x0F; read addr 0x00000 -> rsp_valid exactly 2 cycles after accept, rsp_rdata=0x0F0E..0100, rsp_we=0.
REQ-033 Write addr 0x00103, wdata all 0xAA, wmask=0x00F0; then read 0x00100 -> bytes 7..10 = 0xAA, all others keep preloaded values.
REQ-034 Read addr 0xFFFF8 with mem[0xFFFF8..0xFFFFF]=0x11, mem[0x00000..0x00007]=0x22 -> low 8 bytes 0x11, high 8 bytes 0x22 (wrap).
REQ-035 Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; new req_valid ignored until the handshake.
REQ-036 Assert rst=0 one cycle after a read accept -> rsp_valid stays 0, req_ready=0 during reset, 1 on the first edge after release; a subsequent read returns correct data.
REQ-037 Rebuild with LINE_BYTES=4, READ_LAT=5: read latency 5 cycles, rsp_rdata 32 bits, write with wmask=0 acks after 1 cycle with memory unchanged.

Source files
------------

// File: rtl/line_memory.sv
// line_memory: byte-addressed line memory with one outstanding request.
//
// A request moves LINE_BYTES bytes starting at any byte address. The
// address wraps modulo 2^ADDR_W. Reads take a snapshot of memory on the
// accept edge. Writes commit their masked bytes on the accept edge. Either
// kind is answered after READ_LAT or WRITE_LAT cycles with a single
// response, held until it is consumed.
//
// Ports
//   mclk       memory clock (rising edge)
//   rst        asynchronous active-low reset
//   req_valid  request present            req_ready  request can be accepted
//   req_we     1 = write, 0 = read        req_addr   first byte address
//   req_wdata  write data, byte n -> req_addr+n
//   req_wmask  per-byte write enable
//   rsp_valid  response present           rsp_ready  consumer accepts response
//   rsp_rdata  read data (zero for write acks)
//   rsp_we     req_we of the request being answered
module line_memory #(
    parameter int LINE_BYTES = 16,
    parameter int ADDR_W     = 20,
    parameter int READ_LAT   = 2,
    parameter int WRITE_LAT  = 1
) (
    input  logic                    mclk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [8*LINE_BYTES-1:0] req_wdata,
    input  logic [LINE_BYTES-1:0]   req_wmask,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [8*LINE_BYTES-1:0] rsp_rdata,
    output logic                    rsp_we
);

    localparam int         DATA_W  = 8 * LINE_BYTES;
    localparam logic [3:0] RD_LOAD = 4'(READ_LAT - 1);
    localparam logic [3:0] WR_LOAD = 4'(WRITE_LAT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] data;
    } rsp_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt;
    logic              up;      // low until the first edge after reset release
    logic              accept;
    rsp_t              rsp_q;
    logic [DATA_W-1:0] snap;

    // Storage is deliberately not reset; contents survive rst.
    logic [7:0] mem [0:(2**ADDR_W)-1];

    assign accept    = req_valid & req_ready;
    assign rsp_rdata = rsp_q.data;
    assign rsp_we    = rsp_q.we;

    // Line gather; the ADDR_W-bit sum gives the modulo wrap for free.
    always_comb begin
        snap = '0;
        for (int n = 0; n < LINE_BYTES; n++)
            snap[8*n +: 8] = mem[req_addr + ADDR_W'(n)];
    end

    // Masked scatter. This commits on the accept edge, so a read accepted
    // on a later edge observes it.
    always_ff @(posedge mclk) begin
        if (accept && req_we) begin
            for (int n = 0; n < LINE_BYTES; n++)
                if (req_wmask[n])
                    mem[req_addr + ADDR_W'(n)] <= req_wdata[8*n +: 8];
        end
    end

    // req_ready is held low during reset and rises on the first edge after
    // release.
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) up <= 1'b0;
        else      up <= 1'b1;
    end

    // FSM: state register
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)      state_nxt = WAIT;
            WAIT:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (rsp_ready)   state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE:    req_ready = up;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Latency counter and captured response. The counter is loaded with
    // LAT-1 so that WAIT lasts LAT cycles and RESP begins exactly LAT edges
    // after the accept edge.
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            cnt   <= 4'd0;
            rsp_q <= '0;
        end else if (accept) begin
            cnt        <= req_we ? WR_LOAD : RD_LOAD;
            rsp_q.we   <= req_we;
            rsp_q.data <= req_we ? '0 : snap;
        end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

endmodule
